// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) byte slave, MSB first on the wire.
// ss, sck and mosi are asynchronous to clk; each passes through SYNC_STAGES
// flops, and edges are found by comparing against one extra registered copy.
// Optional build macro: SPI_SLAVE_MISO_TRISTATE_EN -- when defined, miso floats
// (high-Z) while the slave is deselected or in reset; otherwise it is driven 0.
//
// Output contract: done is a one-clk pulse; data_out changes only on the same
// clock edge that raises done and holds its value until the next done. There is
// no back-pressure: the consumer must take data_out while done is high or later.

module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  input  logic [7:0] data_in,
  output logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out
);

  // Synchronizer chains; index SYNC_STAGES-1 is the synchronized value.
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic       ss_s;
  logic       sck_s;
  logic       mosi_s;
  logic       ss_d;
  logic       sck_d;

  logic       ss_fall;
  logic       sck_rise;
  logic       sck_fall;

  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;

  // Synchronize the SPI pins and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_d      <= ss_s;
      sck_d     <= sck_s;
    end
  end

  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];

  assign ss_fall  = ss_d & ~ss_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;

  // busy follows the delayed synchronized select: it rises the cycle after the
  // ss fall is detected and drops the cycle after the ss rise is detected.
  assign busy = ~ss_d;

  // Byte engine: bit counter, RX/TX shift registers, done pulse and data_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= 3'd0;
      tx_sr    <= 8'h00;
      rx_sr    <= 8'h00;
      data_out <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ss_fall) begin
        // Start of a frame wins over any coincident sck edge.
        bit_cnt <= 3'd0;
        tx_sr   <= data_in;
      end else if (ss_s) begin
        // Deselected (including the cycle the rise is seen): drop any partial
        // byte and ignore sck activity.
        bit_cnt <= 3'd0;
      end else begin
        if (sck_rise) begin
          rx_sr   <= {rx_sr[6:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            done     <= 1'b1;
            data_out <= {rx_sr[6:0], mosi_s};
          end
        end
        // The cycle done is high reloads the reply byte. The 8th falling edge
        // of a byte arrives after that reload with the counter already wrapped
        // to 0; shifting there would discard the next byte's MSB, so falling
        // edges shift only while a byte is partly transferred.
        if (done) begin
          tx_sr <= data_in;
        end else if (sck_fall && (bit_cnt != 3'd0)) begin
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  // Release the line whenever this slave is not selected or is in reset.
  assign miso = (!rst || ss_s) ? 1'bz : tx_sr[7];
`else
  // Always driven; parked low while deselected.
  assign miso = ss_s ? 1'b0 : tx_sr[7];
`endif

endmodule
